fetch_ctrl: RTL



---
 rtl/fetch_ctrl_pkg.sv | 26 ++
 rtl/fetch_buf.sv | 53 +++++
 rtl/fetch_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_pkg
// Brief    : Shared state encodings, NOP encoding and PC helper for fetch_ctrl
// Revision : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_FULL   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  localparam logic [15:0] c_NOP_INSTR = 16'h0800;
  localparam logic [15:0] c_RESET_PC  = 16'h0000;

  // 16-bit wrapping PC adder shared by the sequencer
  function automatic logic [15:0] pc_add(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_buf
// Brief    : One-entry holding register for instruction, PC and PC+step
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buf
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic        i_pop,
  input  logic [15:0] i_instr,
  input  logic [15:0] i_pc,
  input  logic [15:0] i_inc_pc,
  output logic        o_valid,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic [15:0] o_inc_pc
);

  logic        r_valid;
  logic [15:0] r_instr;
  logic [15:0] r_pc;
  logic [15:0] r_inc_pc;

  // Payload is only written on load, so flush/pop leave if_* stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_instr  <= c_NOP_INSTR;
      r_pc     <= '0;
      r_inc_pc <= '0;
    end else if (i_load) begin
      r_valid  <= 1'b1;
      r_instr  <= i_instr;
      r_pc     <= i_pc;
      r_inc_pc <= i_inc_pc;
    end else if (i_flush || i_pop) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_instr  = r_instr;
  assign o_pc     = r_pc;
  assign o_inc_pc = r_inc_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Fetch sequencer for a multi-cycle instruction memory, one read
//            outstanding, redirect absorption and a one-entry output buffer
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = c_RESET_PC,
  parameter logic [15:0] PC_STEP  = 16'h0002
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic        mem_stall,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  input  logic        mem_err,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_inc_pc,
  output logic        err
);

  fetch_state_t r_state, w_state_nxt;
  logic [15:0]  r_pc, w_pc_nxt;
  logic         r_drop, w_drop_nxt;
  logic         r_err, w_err_nxt;

  logic         w_req;
  logic         w_accept;
  logic         w_pop;
  logic         w_done;
  logic         w_load;
  logic [15:0]  w_pc_inc;
  logic [15:0]  w_load_instr;
  logic         w_buf_valid;

  assign w_pc_inc     = pc_add(r_pc, PC_STEP);
  assign w_load_instr = mem_err ? c_NOP_INSTR : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ISSUE;
      r_pc    <= RESET_PC;
      r_drop  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_drop  <= w_drop_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop;
    w_err_nxt   = r_err;
    w_req       = 1'b0;

    case (r_state)
      ST_ISSUE:  w_req = !halt && !w_buf_valid;
      ST_FULL:   w_req = if_ready && !halt;
      default:   w_req = 1'b0;
    endcase

    w_accept = w_req && !mem_stall;
    w_pop    = w_buf_valid && if_ready;
    w_done   = (r_state == ST_WAIT) && mem_done;
    w_load   = w_done && !r_drop && !redirect_valid;

    case (r_state)
      ST_ISSUE: begin
        if (halt)            w_state_nxt = ST_HALTED;
        else if (!mem_stall) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_done) begin
          w_drop_nxt  = 1'b0;
          w_state_nxt = (r_drop || redirect_valid) ? ST_ISSUE : ST_FULL;
        end
      end
      ST_FULL: begin
        if (if_ready) begin
          if (halt)            w_state_nxt = ST_HALTED;
          else if (!mem_stall) w_state_nxt = ST_WAIT;
          else                 w_state_nxt = ST_ISSUE;
        end else if (redirect_valid) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_HALTED: begin
        if (!halt)
          w_state_nxt = (w_buf_valid && !if_ready && !redirect_valid) ? ST_FULL : ST_ISSUE;
      end
      default: w_state_nxt = ST_ISSUE;
    endcase

    if (w_load) begin
      w_pc_nxt = w_pc_inc;
      if (mem_err) w_err_nxt = 1'b1;
    end

    // A read accepted or still in flight when a redirect lands is stale
    if (redirect_valid) begin
      w_pc_nxt   = redirect_pc;
      w_drop_nxt = ((r_state == ST_WAIT) && !mem_done) || w_accept;
      if (redirect_pc[0]) w_err_nxt = 1'b1;
    end
  end

  fetch_buf u_fetch_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_flush  (redirect_valid),
    .i_pop    (w_pop),
    .i_instr  (w_load_instr),
    .i_pc     (r_pc),
    .i_inc_pc (w_pc_inc),
    .o_valid  (w_buf_valid),
    .o_instr  (if_instr),
    .o_pc     (if_pc),
    .o_inc_pc (if_inc_pc)
  );

  assign mem_en   = w_req && rst_n;
  assign mem_addr = r_pc;
  assign if_valid = w_buf_valid;
  assign err      = r_err;

endmodule
`default_nettype wire
